// File: rtl/adc_spi_master_pkg.sv
// Shared constants, state encoding and MOSI command helper for the ADC SPI front end.
package microscope_pkg;

  localparam int unsigned ADC_BITS       = 12;
  localparam int unsigned FRAME_SCLKS    = 17;
  localparam int unsigned FIRST_DATA_BIT = 5;
  localparam int unsigned BIT_CNT_W      = 5;

  // bit_cnt values at which each command bit is on mosi (bit 0 is the start bit)
  localparam int unsigned BIT_SGL  = 1;
  localparam int unsigned BIT_ODD  = 2;
  localparam int unsigned BIT_MSBF = 3;

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} adc_state_t;

  function automatic logic cmd_bit(input logic [BIT_CNT_W-1:0] bit_idx,
                                   input logic sgl, input logic odd);
    logic b;
    b = 1'b0;
    if (bit_idx == BIT_CNT_W'(BIT_SGL))       b = sgl;
    else if (bit_idx == BIT_CNT_W'(BIT_ODD))  b = odd;
    else if (bit_idx == BIT_CNT_W'(BIT_MSBF)) b = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/adc_spi_master_if.sv
// Control, status and SPI wire bundle between the ADC front end and its neighbours.
interface adc_spi_master_if;
  import microscope_pkg::*;

  logic                enable;
  logic                channel;
  logic                single_ended;
  logic                miso;
  logic                sclk;
  logic                cs_n;
  logic                mosi;
  logic [ADC_BITS-1:0] sample;
  logic                sample_valid;
  logic                busy;

  modport master (
    input  enable, channel, single_ended, miso,
    output sclk, cs_n, mosi, sample, sample_valid, busy
  );

  modport slave (
    output enable, channel, single_ended, miso,
    input  sclk, cs_n, mosi, sample, sample_valid, busy
  );
endinterface

// File: rtl/adc_spi_master_tick_div.sv
// Half-period tick generator: one tick every HALF_DIV clocks while run is high.
module tick_div #(
  parameter int unsigned HALF_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);
  localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          armed_q, armed_d;

  // The first cycle after run rises only arms the divider; counting starts one cycle later.
  always_comb begin
    armed_d   = run;
    div_cnt_d = div_cnt_q;
    if (!run || !armed_q)                       div_cnt_d = '0;
    else if (div_cnt_q == CW'(HALF_DIV - 1))    div_cnt_d = '0;
    else                                        div_cnt_d = div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      armed_q   <= armed_d;
    end
  end

  assign tick = run && (div_cnt_q == CW'(HALF_DIV - 1));
endmodule

// File: rtl/adc_spi_master.sv
// SPI master for a 12-bit dual-channel SAR ADC with an MCP3202-style command frame.
module adc_spi_master
  import microscope_pkg::*;
#(
  parameter int unsigned HALF_DIV       = 16,
  parameter int unsigned CS_HIGH_HALVES = 2
) (
  input logic              clk,
  input logic              reset,
  adc_spi_master_if.master bus
);
  localparam int unsigned HW = (CS_HIGH_HALVES > 1) ? $clog2(CS_HIGH_HALVES) : 1;

  if (HALF_DIV < 2) begin : g_half_div_check
    $error("adc_spi_master: HALF_DIV must be at least 2");
  end
  if (CS_HIGH_HALVES < 1) begin : g_cs_high_check
    $error("adc_spi_master: CS_HIGH_HALVES must be at least 1");
  end

  adc_state_t            state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [ADC_BITS-1:0]   shift_q, shift_d;
  logic [ADC_BITS-1:0]   sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  sgl_q, sgl_d;
  logic                  odd_q, odd_d;
  logic                  tick;

  tick_div #(.HALF_DIV(HALF_DIV)) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .run   (state_q != IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    shift_d    = shift_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    sgl_d      = sgl_q;
    odd_d      = odd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d    = CS_SETUP;
          cs_n_d     = 1'b0;
          mosi_d     = 1'b1;
          busy_d     = 1'b1;
          sgl_d      = bus.single_ended;
          odd_d      = bus.channel;
          bit_cnt_d  = '0;
          hold_cnt_d = '0;
        end
      end
      CS_SETUP: begin
        if (tick) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (bit_cnt_q >= BIT_CNT_W'(FIRST_DATA_BIT))
              shift_d = {shift_q[ADC_BITS-2:0], bus.miso};
          end else if (bit_cnt_q == BIT_CNT_W'(FRAME_SCLKS - 1)) begin
            state_d    = CS_HOLD;
            sclk_d     = 1'b0;
            cs_n_d     = 1'b1;
            mosi_d     = 1'b0;
            sample_d   = shift_q;
            valid_d    = 1'b1;
            hold_cnt_d = '0;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            mosi_d    = cmd_bit(bit_cnt_q + 1'b1, sgl_q, odd_q);
          end
        end
      end
      CS_HOLD: begin
        if (tick) begin
          if (hold_cnt_q == HW'(CS_HIGH_HALVES - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      shift_q    <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      sgl_q      <= 1'b0;
      odd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      shift_q    <= shift_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      sgl_q      <= sgl_d;
      odd_q      <= odd_d;
    end
  end

  assign bus.sclk         = sclk_q;
  assign bus.cs_n         = cs_n_q;
  assign bus.mosi         = mosi_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;
endmodule
